// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus signals of apb_master_bridge.
// The master modport is the bridge's view; slave is the view of whatever sits around it.
interface apb_master_bridge_if #(
  parameter int unsigned NUM_SLV = 2
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [31:0]        cmd_addr;
  logic [31:0]        cmd_wdata;
  logic [2:0]         cmd_prot;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;

  logic [31:0]        PADDR;
  logic [NUM_SLV-1:0] PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [2:0]         PPROT;
  logic [31:0]        PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator fed by a valid/ready command port.
// Define APB_MASTER_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
  parameter int unsigned NUM_SLV        = 2,
  parameter int unsigned SEL_BIT        = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_master_bridge_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e             state_q, state_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [2:0]         pprot_q, pprot_d;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [1:0]         cmd_idx;
  logic               cmd_hit;
  logic [NUM_SLV-1:0] cmd_sel;
  logic               timeout;

  assign cmd_idx = bus_io.cmd_addr[SEL_BIT+1:SEL_BIT];
  assign cmd_hit = 32'(cmd_idx) < NUM_SLV;

  always_comb begin
    cmd_sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      cmd_sel[i] = (32'(cmd_idx) == i);
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Cleared during SETUP so every ACCESS phase starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StSetup) begin
      cnt_d = '0;
    end else if (state_q == StAccess && !bus_io.PREADY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    pprot_d   = pprot_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          paddr_d  = bus_io.cmd_addr;
          pwdata_d = bus_io.cmd_wdata;
          pwrite_d = bus_io.cmd_write;
          pprot_d  = bus_io.cmd_prot;
          if (cmd_hit) begin
            psel_d  = cmd_sel;
            state_d = StSetup;
          end else begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        // PREADY is checked first so a completion on the limit cycle still wins.
        if (bus_io.PREADY) begin
          rdata_d   = (pwrite_q || bus_io.PSLVERR) ? '0 : bus_io.PRDATA;
          err_d     = bus_io.PSLVERR;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = StResp;
        end else if (timeout) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pprot_q   <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      pprot_q   <= pprot_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Gated by PRESETn so the command port is closed for the whole reset pulse.
  assign bus_io.cmd_ready = (state_q == StIdle) && PRESETn;
  assign bus_io.rsp_valid = (state_q == StResp);
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;

  assign bus_io.PADDR   = paddr_q;
  assign bus_io.PSEL    = psel_q;
  assign bus_io.PENABLE = penable_q;
  assign bus_io.PWRITE  = pwrite_q;
  assign bus_io.PWDATA  = pwdata_q;
  assign bus_io.PPROT   = pprot_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a memory-backed APB slave model, a scoreboard of expected
// responses filled at command issue, and a response monitor that pops and compares.
module tb_apb_master_bridge;

  localparam int unsigned NumSlv        = 2;
  localparam int unsigned TimeoutCycles = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [2:0]  prot;
  } apb_t;

  logic PCLK;
  logic PRESETn;

  apb_master_bridge_if #(.NUM_SLV(NumSlv)) bus ();

  apb_master_bridge #(
    .NUM_SLV       (NumSlv),
    .SEL_BIT       (12),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus_io (bus)
  );

  rsp_t        exp_q[$];
  apb_t        apb_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] bfm_mem[logic [31:0]];

  int n_checks    = 0;
  int n_fail      = 0;
  int bfm_wait    = -1;
  bit bfm_hang    = 0;
  bit sink_hold   = 0;
  bit sink_always = 1;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Environment rules: unwritten words read back a pattern; word offset 0xF errors.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic slv_err(input logic [31:0] a);
    return a[5:2] == 4'hF;
  endfunction

  // Reference model: decide the response when the command is issued.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] prot, input bit abort);
    rsp_t r;
    int   n;
    if (32'(addr[13:12]) >= NumSlv) begin
      r = '{rdata: 32'h0, err: 1'b1};
    end else begin
      apb_q.push_back('{addr: addr, wdata: wdata, wr: wr, prot: prot});
      if (abort || slv_err(addr)) begin
        r = '{rdata: 32'h0, err: 1'b1};
      end else if (wr) begin
        ref_mem[addr] = wdata;
        r = '{rdata: 32'h0, err: 1'b0};
      end else begin
        r = '{rdata: ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr), err: 1'b0};
      end
    end
    exp_q.push_back(r);
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_prot  = prot;
    n = 0;
    while (!bus.cmd_ready && n < 400) begin
      @(negedge PCLK);
      n++;
    end
    if (!bus.cmd_ready) fail_event("cmd_accept_timeout");
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    bus.cmd_prot  = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge PCLK);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // APB slave model: checks each SETUP/ACCESS against the issued command, adds wait states.
  initial begin : apb_slave
    apb_t              cur;
    logic [NumSlv-1:0] exp_sel;
    logic [31:0]       a;
    int                waits;
    cur     = '0;
    exp_sel = '0;
    waits   = 0;
    bus.PREADY  = 1'b0;
    bus.PRDATA  = '0;
    bus.PSLVERR = 1'b0;
    forever begin
      @(negedge PCLK);
      bus.PREADY  = 1'($urandom);
      bus.PRDATA  = $urandom;
      bus.PSLVERR = 1'($urandom);
      if (!PRESETn) continue;
      if (bus.PENABLE && bus.PSEL == '0) fail_event("penable_without_psel");
      if ($countones(bus.PSEL) > 1) fail_event("psel_not_onehot");
      if (bus.PSEL != '0 && !bus.PENABLE) begin
        if (apb_q.size() == 0) begin
          fail_event("unexpected_setup");
        end else begin
          cur     = apb_q.pop_front();
          exp_sel = NumSlv'(1) << cur.addr[13:12];
          check("setup_psel", 64'(bus.PSEL), 64'(exp_sel));
          check("setup_paddr", 64'(bus.PADDR), 64'(cur.addr));
          check("setup_pwdata", 64'(bus.PWDATA), 64'(cur.wdata));
          check("setup_ctl", 64'({bus.PWRITE, bus.PPROT}), 64'({cur.wr, cur.prot}));
        end
        waits = (bfm_wait >= 0) ? bfm_wait : int'($urandom_range(0, 3));
      end else if (bus.PSEL != '0) begin
        check("access_hold", {bus.PADDR, bus.PWDATA}, {cur.addr, cur.wdata});
        check("access_ctl", 64'({bus.PSEL, bus.PWRITE, bus.PPROT}),
              64'({exp_sel, cur.wr, cur.prot}));
        if (bfm_hang || waits > 0) begin
          bus.PREADY = 1'b0;
          if (waits > 0) waits--;
        end else begin
          a = bus.PADDR;
          bus.PREADY  = 1'b1;
          bus.PSLVERR = slv_err(a);
          if (!bus.PSLVERR) begin
            if (bus.PWRITE) bfm_mem[a] = bus.PWDATA;
            else bus.PRDATA = bfm_mem.exists(a) ? bfm_mem[a] : dflt(a);
          end
        end
      end
    end
  end

  // Response sink and scoreboard monitor.
  initial begin : rsp_monitor
    rsp_t        e;
    logic        held;
    logic [31:0] h_rdata;
    logic        h_err;
    held    = 1'b0;
    h_rdata = '0;
    h_err   = 1'b0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        held = 1'b0;
        bus.rsp_ready = 1'b0;
        continue;
      end
      if (held) begin
        check("rsp_stable", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
              64'({1'b1, h_err, h_rdata}));
      end
      bus.rsp_ready = sink_hold ? 1'b0 : sink_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      held = 1'b0;
      if (bus.rsp_valid) begin
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            fail_event("unexpected_rsp");
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          end
        end else begin
          held    = 1'b1;
          h_rdata = bus.rsp_rdata;
          h_err   = bus.rsp_err;
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    PRESETn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_prot  = '0;
    ref_mem[32'h0000_1000] = 32'h0000_003C;
    bfm_mem[32'h0000_1000] = 32'h0000_003C;

    // Reset values
    repeat (3) @(negedge PCLK);
    check("rst_ctl", 64'({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PPROT,
                          bus.rsp_valid, bus.rsp_err}), 64'd0);
    check("rst_paddr", 64'(bus.PADDR), 64'd0);
    check("rst_pwdata", 64'(bus.PWDATA), 64'd0);
    check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("rst_release_ready", 64'(bus.cmd_ready), 64'd1);

    // Zero-wait write to slave 0: cycle-exact phase sequence
    bfm_wait    = 0;
    sink_always = 1;
    issue(1'b1, 32'h0000_0004, 32'h0000_00A5, 3'd0, 1'b0);
    @(negedge PCLK);
    check("t1_setup", 64'({bus.PSEL, bus.PENABLE}), 64'({2'b01, 1'b0}));
    check("t1_setup_pwdata", 64'(bus.PWDATA), 64'h0000_00A5);
    @(negedge PCLK);
    check("t1_access", 64'({bus.PSEL, bus.PENABLE}), 64'({2'b01, 1'b1}));
    check("t1_access_pwdata", 64'(bus.PWDATA), 64'h0000_00A5);
    @(negedge PCLK);
    check("t1_rsp", 64'({bus.rsp_valid, bus.PSEL, bus.PENABLE}), 64'({1'b1, 2'b00, 1'b0}));
    @(negedge PCLK);
    check("t1_done", 64'({bus.rsp_valid, bus.cmd_ready}), 64'({1'b0, 1'b1}));

    // Read from slave 1 with three wait states
    bfm_wait = 3;
    issue(1'b0, 32'h0000_1000, 32'h0, 3'd5, 1'b0);
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge PCLK);
      if (bus.PSEL == 2'b10) n++;
      else break;
    end
    check("t2_psel_cycles", 64'(n), 64'd5);
    drain();

    // Slave error, then response back-pressure
    bfm_wait  = 0;
    sink_hold = 1;
    issue(1'b0, 32'h0000_103C, 32'h0, 3'd0, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge PCLK);
      check("t3_hold_ctl", 64'({bus.rsp_valid, bus.rsp_err, bus.cmd_ready}), 64'(3'b110));
      check("t3_hold_rdata", 64'(bus.rsp_rdata), 64'd0);
    end
    sink_hold = 0;
    drain();

    // Decode error: index 3 has no slave
    issue(1'b0, 32'h0000_3000, 32'h0, 3'd0, 1'b0);
    @(negedge PCLK);
    check("t4_decerr", 64'({bus.rsp_valid, bus.rsp_err, bus.PSEL, bus.PENABLE}),
          64'({1'b1, 1'b1, 2'b00, 1'b0}));
    check("t4_decerr_rdata", 64'(bus.rsp_rdata), 64'd0);
    drain();

    // Asynchronous reset during ACCESS
    bfm_hang = 1;
    issue(1'b0, 32'h0000_1008, 32'h0, 3'd2, 1'b0);
    n = 0;
    while (!bus.PENABLE && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    check("t5_in_access", 64'(bus.PENABLE), 64'd1);
    PRESETn = 1'b0;
    #1;
    check("t5_async_drop", 64'({bus.PSEL, bus.PENABLE, bus.rsp_valid}), 64'd0);
    exp_q.delete();
    apb_q.delete();
    bfm_hang = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("t5_ready_after", 64'(bus.cmd_ready), 64'd1);
    bfm_wait = -1;
    issue(1'b1, 32'h0000_1010, 32'hDEAD_BEEF, 3'd1, 1'b0);
    issue(1'b0, 32'h0000_1010, 32'h0, 3'd1, 1'b0);
    drain();

    // PREADY stuck low
    bfm_hang = 1;
`ifdef APB_MASTER_TIMEOUT_EN
    issue(1'b0, 32'h0000_0020, 32'h0, 3'd0, 1'b1);
    n = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge PCLK);
      if (bus.PSEL == '0) break;
      if (bus.PENABLE) n++;
    end
    check("t6_timeout_cycles", 64'(n), 64'(TimeoutCycles));
    bfm_hang = 0;
`else
    issue(1'b0, 32'h0000_0020, 32'h0, 3'd0, 1'b0);
    n = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge PCLK);
      if (bus.PSEL == 2'b01) n++;
    end
    check("t6_no_timeout", 64'(n), 64'd110);
    bfm_hang = 0;
`endif
    drain();

    // Randomized traffic with random wait states and response back-pressure
    sink_always = 0;
    bfm_wait    = -1;
    for (int t = 0; t < 40; t++) begin
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 7);
      a = {18'h0, (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : 2'(r - 4), 6'h0, 4'($urandom), 2'b00};
      issue(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom), 1'b0);
    end
    drain();
    sink_always = 1;
    check("apb_q_empty", 64'(apb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
